// File: rtl/gpio_apb_arbiter.sv
// Two-requester round-robin arbiter driving a single APB GPIO slave (IDLE/SETUP/ACCESS/DONE).
// Optional ACCESS timeout abort is enabled by defining GPIO_ARB_TIMEOUT_EN.
module gpio_apb_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        pclk,
    input  logic        preset_n,
    input  logic [1:0]  req_i,
    input  logic [1:0]  write_i,
    input  logic [7:0]  addr_i,
    input  logic [15:0] wdata_i,
    output logic [1:0]  gnt_o,
    output logic [1:0]  done_o,
    output logic [7:0]  rdata_o,
    output logic        err_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic [3:0]  paddr_o,
    output logic        pwrite_o,
    output logic [7:0]  pwdata_o,
    input  logic [7:0]  prdata_i,
    input  logic        pready_i
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        prio_q, prio_d;
    logic [3:0]  addr_q, addr_d;
    logic        write_q, write_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        win;

`ifdef GPIO_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef GPIO_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef GPIO_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        win     = 1'b0;
`ifdef GPIO_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                // prio_q names the requester that wins a tie
                win = (req_i == 2'b11) ? prio_q : req_i[1];
                if (req_i != 2'b00) begin
                    owner_d = win;
                    addr_d  = win ? addr_i[7:4]  : addr_i[3:0];
                    write_d = win ? write_i[1]   : write_i[0];
                    wdata_d = win ? wdata_i[15:8] : wdata_i[7:0];
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
`ifdef GPIO_ARB_TIMEOUT_EN
                cnt_d   = '0;
                err_d   = 1'b0;
`endif
            end
            ACCESS: begin
                if (pready_i) begin
                    state_d = DONE;
                    if (!write_q) begin
                        rdata_d = prdata_i;
                    end
                end
`ifdef GPIO_ARB_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == CW'(TIMEOUT)) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
                end
`endif
            end
            DONE: begin
                prio_d  = ~owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        psel_o    = (state_q == SETUP) || (state_q == ACCESS);
        penable_o = (state_q == ACCESS);
        paddr_o   = psel_o ? addr_q  : 4'h0;
        pwrite_o  = psel_o ? write_q : 1'b0;
        pwdata_o  = psel_o ? wdata_q : 8'h00;
        gnt_o     = (state_q == IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
        done_o    = (state_q == DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
        rdata_o   = rdata_q;
`ifdef GPIO_ARB_TIMEOUT_EN
        err_o     = (state_q == DONE) && err_q;
`else
        err_o     = 1'b0;
`endif
    end

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// Self-checking bench for gpio_apb_arbiter: vector table plus hand sequences, scoreboard queue
// of expected completions compared when done_o pulses. Also exercises GPIO_ARB_TIMEOUT_EN if defined.
module tb_gpio_apb_arbiter;

    localparam int TIMEOUT = 15;

    logic        pclk, preset_n;
    logic [1:0]  req_i, write_i;
    logic [7:0]  addr_i;
    logic [15:0] wdata_i;
    logic [1:0]  gnt_o, done_o;
    logic [7:0]  rdata_o;
    logic        err_o, psel_o, penable_o, pwrite_o;
    logic [3:0]  paddr_o;
    logic [7:0]  pwdata_o, prdata_i;
    logic        pready_i;

    gpio_apb_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .preset_n(preset_n), .req_i(req_i), .write_i(write_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .done_o(done_o),
        .rdata_o(rdata_o), .err_o(err_o), .psel_o(psel_o), .penable_o(penable_o),
        .paddr_o(paddr_o), .pwrite_o(pwrite_o), .pwdata_o(pwdata_o),
        .prdata_i(prdata_i), .pready_i(pready_i)
    );

    typedef struct {
        logic [1:0] done;
        logic [3:0] paddr;
        logic       pwrite;
        logic [7:0] pwdata;
        logic [7:0] rdata;
        logic       err;
        int         acc;
    } exp_t;

    typedef struct {
        int         who;
        logic       wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        int         waits;
        logic [7:0] prdata;
        logic       drop;
        logic       tmo;
    } vec_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_rdata = 8'h00;
    int         slave_waits = 0;
    logic [7:0] slave_prdata = 8'h00;
    int         acc_cnt = 0;
    int         last_acc = 0;
    logic [1:0] prev_done = 2'b00;

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // APB slave model: pready rises after slave_waits stalled ACCESS cycles
    always @(negedge pclk) begin
        prdata_i <= slave_prdata;
        if (psel_o && penable_o) begin
            acc_cnt  = acc_cnt + 1;
            last_acc = acc_cnt;
            pready_i = (acc_cnt > slave_waits);
        end else begin
            acc_cnt  = 0;
            pready_i = 1'b0;
        end
    end

    // Bus checker: outputs during a transfer must match the scoreboard head
    always @(negedge pclk) begin
        if (preset_n) begin
            if (psel_o) begin
                if (sb.size() == 0) begin
                    chk("psel_without_request", 32'(psel_o), 32'd0);
                end else begin
                    chk("gnt", 32'(gnt_o), 32'(sb[0].done));
                    chk("paddr", 32'(paddr_o), 32'(sb[0].paddr));
                    chk("pwrite", 32'(pwrite_o), 32'(sb[0].pwrite));
                    chk("pwdata", 32'(pwdata_o), 32'(sb[0].pwdata));
                end
            end else begin
                chk("idle_penable", 32'(penable_o), 32'd0);
                chk("idle_bus", {19'd0, paddr_o, pwrite_o, pwdata_o}, 32'd0);
                if (done_o == 2'b00) begin
                    chk("idle_gnt", 32'(gnt_o), 32'd0);
                    chk("idle_err", 32'(err_o), 32'd0);
                end
            end
        end
    end

    // Completion monitor
    always @(negedge pclk) begin
        exp_t e;
        if (preset_n && done_o != 2'b00) begin
            if (prev_done != 2'b00) chk("done_single_cycle", 32'(prev_done), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done_o), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("done", 32'(done_o), 32'(e.done));
                chk("done_gnt", 32'(gnt_o), 32'(e.done));
                chk("rdata", 32'(rdata_o), 32'(e.rdata));
                chk("err", 32'(err_o), 32'(e.err));
                chk("access_cycles", 32'(last_acc), 32'(e.acc));
            end
        end
        prev_done = preset_n ? done_o : 2'b00;
    end

    task automatic run_vec(input vec_t v);
        exp_t e;
        bit   seen = 0;
        bit   got = 0;
        e.done   = (v.who == 1) ? 2'b10 : 2'b01;
        e.paddr  = v.addr;
        e.pwrite = v.wr;
        e.pwdata = v.wdata;
        e.err    = v.tmo;
        e.acc    = v.tmo ? TIMEOUT : v.waits + 1;
        e.rdata  = (!v.wr && !v.tmo) ? v.prdata : model_rdata;
        model_rdata = e.rdata;
        sb.push_back(e);
        slave_waits  = v.tmo ? 100000 : v.waits;
        slave_prdata = v.prdata;
        req_i   = e.done;
        write_i = (v.who == 1) ? {v.wr, ~v.wr} : {~v.wr, v.wr};
        addr_i  = (v.who == 1) ? {v.addr, ~v.addr} : {~v.addr, v.addr};
        wdata_i = (v.who == 1) ? {v.wdata, ~v.wdata} : {~v.wdata, v.wdata};
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge pclk);
            if (psel_o && !penable_o && !seen) begin
                seen    = 1;
                addr_i  = ~addr_i;
                wdata_i = ~wdata_i;
                write_i = ~write_i;
                if (v.drop) req_i = 2'b00;
            end
            if (done_o != 2'b00) begin
                got   = 1;
                req_i = 2'b00;
            end
        end
        if (!got) chk("vector_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input string nm, input int budget);
        bit got = 0;
        for (int n = 0; n < budget && !got; n++) begin
            @(negedge pclk);
            if (done_o != 2'b00) begin
                got   = 1;
                req_i = 2'b00;
            end
        end
        if (!got) chk(nm, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge pclk);
        preset_n = 1'b0;
        model_rdata = 8'h00;
        repeat (2) @(negedge pclk);
        preset_n = 1'b1;
    endtask

    vec_t vecs[6];
    exp_t e;
    int   cnt;
    bit   hit;

    initial begin
        preset_n = 1'b0; req_i = 2'b00; write_i = 2'b00; addr_i = 8'h00;
        wdata_i = 16'h0000; pready_i = 1'b0; prdata_i = 8'h00;

        vecs[0] = '{who:0, wr:1'b1, addr:4'h3, wdata:8'h12, waits:0, prdata:8'h00, drop:1'b0, tmo:1'b0};
        vecs[1] = '{who:1, wr:1'b0, addr:4'h2, wdata:8'h34, waits:3, prdata:8'h5A, drop:1'b0, tmo:1'b0};
        vecs[2] = '{who:0, wr:1'b0, addr:4'h1, wdata:8'h56, waits:1, prdata:8'hC3, drop:1'b1, tmo:1'b0};
        vecs[3] = '{who:1, wr:1'b1, addr:4'hF, wdata:8'h81, waits:2, prdata:8'hEE, drop:1'b0, tmo:1'b0};
        vecs[4] = '{who:0, wr:1'b0, addr:4'h7, wdata:8'h9C, waits:0, prdata:8'h96, drop:1'b0, tmo:1'b0};
        vecs[5] = '{who:1, wr:1'b1, addr:4'h0, wdata:8'h00, waits:0, prdata:8'h44, drop:1'b1, tmo:1'b0};

        repeat (2) @(negedge pclk);
        chk("rst_psel", 32'(psel_o), 32'd0);
        chk("rst_penable", 32'(penable_o), 32'd0);
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_rdata", 32'(rdata_o), 32'd0);
        preset_n = 1'b1;

        // Single write with exact phase timing
        @(negedge pclk);
        e = '{done:2'b01, paddr:4'h0, pwrite:1'b1, pwdata:8'hFF, rdata:8'h00, err:1'b0, acc:1};
        sb.push_back(e);
        slave_waits = 0;
        req_i = 2'b01; write_i = 2'b01; addr_i = 8'h50; wdata_i = 16'h00FF;
        @(negedge pclk);
        chk("c1_psel_penable", {30'd0, psel_o, penable_o}, 32'b10);
        @(negedge pclk);
        chk("c2_psel_penable", {30'd0, psel_o, penable_o}, 32'b11);
        @(negedge pclk);
        chk("c3_done", 32'(done_o), 32'b01);
        req_i = 2'b00;

        foreach (vecs[i]) run_vec(vecs[i]);

`ifdef GPIO_ARB_TIMEOUT_EN
        run_vec('{who:0, wr:1'b0, addr:4'h2, wdata:8'h00, waits:0, prdata:8'hDD, drop:1'b0, tmo:1'b1});
`endif

        // Reset during a stalled ACCESS, then re-grant of the still-pending request
        @(negedge pclk);
        e = '{done:2'b10, paddr:4'h5, pwrite:1'b0, pwdata:8'h11, rdata:8'h3C, err:1'b0, acc:1};
        sb.push_back(e);
        slave_waits = 100000; slave_prdata = 8'h3C;
        req_i = 2'b10; write_i = 2'b00; addr_i = 8'h5A; wdata_i = 16'h1122;
        hit = 0;
        for (int n = 0; n < 10 && !hit; n++) begin
            @(negedge pclk);
            hit = psel_o && penable_o;
        end
        chk("reach_access", 32'(hit), 32'd1);
        cnt = 0;
`ifdef GPIO_ARB_TIMEOUT_EN
        for (int n = 0; n < 3; n++) begin
            @(negedge pclk);
            if (psel_o && penable_o) cnt++;
        end
        chk("access_hold", 32'(cnt), 32'd3);
`else
        for (int n = 0; n < 100; n++) begin
            @(negedge pclk);
            if (psel_o && penable_o) cnt++;
        end
        chk("access_hold_100", 32'(cnt), 32'd100);
`endif
        #2 preset_n = 1'b0;
        #1;
        chk("async_rst_psel", {30'd0, psel_o, penable_o}, 32'd0);
        chk("async_rst_done", 32'(done_o), 32'd0);
        chk("async_rst_gnt", 32'(gnt_o), 32'd0);
        chk("async_rst_rdata", 32'(rdata_o), 32'd0);
        model_rdata = 8'h00;
        slave_waits = 0;
        @(negedge pclk);
        preset_n = 1'b1;
        wait_done("regrant_timeout", 20);

        // Both requesting continuously after reset: 0,1,0,1
        do_reset();
        e = '{done:2'b01, paddr:4'h1, pwrite:1'b1, pwdata:8'hAA, rdata:8'h00, err:1'b0, acc:1};
        sb.push_back(e);
        e = '{done:2'b10, paddr:4'h9, pwrite:1'b0, pwdata:8'h55, rdata:8'h77, err:1'b0, acc:1};
        sb.push_back(e);
        e = '{done:2'b01, paddr:4'h1, pwrite:1'b1, pwdata:8'hAA, rdata:8'h77, err:1'b0, acc:1};
        sb.push_back(e);
        e = '{done:2'b10, paddr:4'h9, pwrite:1'b0, pwdata:8'h55, rdata:8'h77, err:1'b0, acc:1};
        sb.push_back(e);
        slave_waits = 0; slave_prdata = 8'h77;
        req_i = 2'b11; write_i = 2'b01; addr_i = 8'h91; wdata_i = 16'h55AA;
        cnt = 0;
        for (int n = 0; n < 40 && cnt < 4; n++) begin
            @(negedge pclk);
            if (done_o != 2'b00) cnt++;
        end
        req_i = 2'b00;
        chk("rr_done_count", 32'(cnt), 32'd4);

        repeat (4) @(negedge pclk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
